// File: rtl/alu_iter.sv
// Parametrised ALU with single-cycle logic/arith ops and iterative MUL/DIV.
// Define ALU_DIV_EN to build the restoring divider; otherwise DIV is a stub.
module alu_iter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             ar_flag,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             out_en,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_d;
    logic [3:0]         r_flags;
    logic               r_done;
    logic [2*WIDTH-1:0] r_p;
    logic [SHW-1:0]     r_cnt;

    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_upd;
    logic               w_go_mul;
    logic               w_go_div;
    logic [SHW-1:0]     w_amt;
    logic               w_amt_nz;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_rol;
    logic [WIDTH-1:0]   w_ror;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_p_nxt;
    logic               w_cv;

    assign w_amt    = src2[SHW-1:0];
    assign w_amt_nz = |w_amt;
    assign w_add    = {1'b0, src1} + {1'b0, src2};
    assign w_sub    = {1'b0, src1} - {1'b0, src2};
    // Extra bit on the shift wires captures the bit shifted out.
    assign w_shl    = {1'b0, src1} << w_amt;
    assign w_shr    = {src1, 1'b0} >> w_amt;
    assign w_rol    = WIDTH'(({src1, src1} << w_amt) >> WIDTH);
    assign w_ror    = WIDTH'({src1, src1} >> w_amt);

    always_comb begin
        w_res    = r_res;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_upd    = 1'b1;
        w_go_mul = 1'b0;
        w_go_div = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                        (w_add[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_MUL: w_go_mul = 1'b1;
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (|src2) begin
                    w_go_div = 1'b1;
                end else begin
                    w_res = '1;
                    w_v   = 1'b1;
                end
`else
                w_res = '0;
                w_v   = 1'b1;
`endif
            end
            OP_AND: w_res = src1 & src2;
            OP_OR:  w_res = src1 | src2;
            OP_XOR: w_res = src1 ^ src2;
            OP_SHL: begin
                if (ar_flag) begin
                    w_res = w_rol;
                    w_c   = w_amt_nz & w_rol[0];
                end else begin
                    {w_c, w_res} = w_shl;
                end
            end
            OP_SHR: begin
                if (ar_flag) begin
                    w_res = w_ror;
                    w_c   = w_amt_nz & w_ror[WIDTH-1];
                end else begin
                    {w_res, w_c} = w_shr;
                end
            end
            default: w_upd = 1'b0;
        endcase
    end

    // r_p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    assign w_msum = {1'b0, r_p[2*WIDTH-1:WIDTH]} +
                    (r_p[0] ? {1'b0, r_d} : '0);

`ifdef ALU_DIV_EN
    logic [WIDTH:0] w_dsh;
    logic [WIDTH:0] w_ddif;

    assign w_dsh  = r_p[2*WIDTH-1:WIDTH-1];
    assign w_ddif = w_dsh - {1'b0, r_d};
`endif

    always_comb begin
        w_p_nxt = {w_msum, r_p[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        if (r_state == S_DIV) begin
            if (w_ddif[WIDTH])
                w_p_nxt = {w_dsh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
            else
                w_p_nxt = {w_ddif[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
        end
`endif
    end

    assign w_cv = (r_state == S_MUL) && (|w_p_nxt[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_res   <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_p     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_go_mul || w_go_div) begin
                            r_state <= w_go_mul ? S_MUL : S_DIV;
                            r_d     <= w_go_mul ? src1 : src2;
                            r_p     <= {{WIDTH{1'b0}},
                                        (w_go_mul ? src2 : src1)};
                            r_cnt   <= '0;
                        end else begin
                            r_done <= 1'b1;
                            if (w_upd) begin
                                r_res   <= w_res;
                                r_flags <= {~|w_res, w_res[WIDTH-1],
                                            w_c, w_v};
                            end
                        end
                    end
                end
                default: begin
                    r_p   <= w_p_nxt;
                    r_cnt <= r_cnt + SHW'(1);
                    if (&r_cnt) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_res   <= w_p_nxt[WIDTH-1:0];
                        r_flags <= {~|w_p_nxt[WIDTH-1:0],
                                    w_p_nxt[WIDTH-1], w_cv, w_cv};
                    end
                end
            endcase
        end
    end

    assign out   = out_en ? r_res : 'z;
    assign flags = r_flags;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=16.
// DIV expectations follow ALU_DIV_EN.
module tb_alu_iter;
    localparam int W = 16;
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic         ar_flag;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         out_en;
    logic [W-1:0] out;
    logic [3:0]   flags;
    logic         busy;
    logic         done;

    int n_run  = 0;
    int n_fail = 0;
    int lat, nbusy, ndone;

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .ar_flag(ar_flag), .src1(src1), .src2(src2), .out_en(out_en),
        .out(out), .flags(flags), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic ar,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        opcode  = op;
        ar_flag = ar;
        src1    = a;
        src2    = b;
        start   = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op,
                          input logic ar, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eo,
                          input logic [3:0] ef);
        issue(op, ar, a, b);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_out"}, 32'(out), 32'(eo));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
    endtask

    // lat counts edges from the start edge (inclusive) to the first done.
    task automatic run_multi(input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int poke,
                             output int l, output int nb, output int nd);
        issue(op, 1'b0, a, b);
        l  = 1;
        nb = 0;
        nd = 0;
        while (!done && l < 40) begin
            if (busy) nb++;
            if (l == poke) begin
                @(negedge clk);
                opcode = OP_ADD;
                src1   = 16'd1;
                src2   = 16'd1;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            l++;
        end
        if (done) nd = 1;
        repeat (3) begin
            tick();
            if (done) nd++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        opcode  = OP_NOP;
        ar_flag = 1'b0;
        src1    = '0;
        src2    = '0;
        out_en  = 1'b1;
        repeat (2) tick();
        chk("rst_out", 32'(out), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;

        single("add", OP_ADD, 1'b0, 16'd10, 16'd5, 16'd15, 4'b0000);
        out_en = 1'b0;
        #1;
        chk("oe_off", 32'((out === 16'hzzzz) || (out === 16'h0000)), 1);
        out_en = 1'b1;
        #1;
        chk("oe_on", 32'(out), 15);
        tick();
        chk("done_pulse", 32'(done), 0);

        single("sub_neg", OP_SUB, 1'b0, 16'd5, 16'd10, 16'd65531, 4'b0110);
        single("sub_zero", OP_SUB, 1'b0, 16'd10, 16'd10, 16'd0, 4'b1000);
        single("nop", OP_NOP, 1'b0, 16'd123, 16'd45, 16'd0, 4'b1000);
        single("add_ovf", OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000,
               4'b0101);
        single("add_cry", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000,
               4'b1010);
        single("and", OP_AND, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
        single("or", OP_OR, 1'b0, 16'h00F0, 16'h000F, 16'h00FF, 4'b0000);
        single("xor", OP_XOR, 1'b0, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000);

        single("rol", OP_SHL, 1'b1, 16'h8001, 16'd1, 16'h0003, 4'b0010);
        single("shl", OP_SHL, 1'b0, 16'h8001, 16'd1, 16'h0002, 4'b0010);
        single("shr17", OP_SHR, 1'b0, 16'd10, 16'd17, 16'd5, 4'b0000);
        single("ror", OP_SHR, 1'b1, 16'h0001, 16'd1, 16'h8000, 4'b0110);
        single("shl0", OP_SHL, 1'b0, 16'h8001, 16'd16, 16'h8001, 4'b0100);

        run_multi(OP_MUL, 16'd300, 16'd300, 5, lat, nbusy, ndone);
        chk("mul_lat", 32'(lat), 17);
        chk("mul_busy", 32'(nbusy), 16);
        chk("mul_ndone", 32'(ndone), 1);
        chk("mul_out", 32'(out), 24464);
        chk("mul_flags", 32'(flags), 4'b0011);

`ifdef ALU_DIV_EN
        run_multi(OP_DIV, 16'd10, 16'd5, 0, lat, nbusy, ndone);
        chk("div_lat", 32'(lat), 17);
        chk("div_out", 32'(out), 2);
        single("div0", OP_DIV, 1'b0, 16'd7, 16'd0, 16'hFFFF, 4'b0101);
        chk("div0_busy", 32'(busy), 0);
`else
        single("div_off", OP_DIV, 1'b0, 16'd10, 16'd5, 16'd0, 4'b1001);
        chk("div_off_busy", 32'(busy), 0);
`endif

        issue(OP_MUL, 1'b0, 16'd300, 16'd300);
        repeat (4) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out", 32'(out), 0);
        chk("abort_flags", 32'(flags), 0);
        ndone = 0;
        repeat (20) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 0);
        single("add_post", OP_ADD, 1'b0, 16'd10, 16'd5, 16'd15, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised successor to the tiny16 single-cycle ALU. Same opcode map, ar_flag shift/rotate select, out_en bus gating and 4-bit flags.
- Adds generic WIDTH, a start/busy/done handshake, and iterative shift-add MUL and restoring DIV so wide datapaths meet timing.
- Sits between the register file and the result bus. The control unit issues start and stalls on busy.

Parameters:
WIDTH, 16, datapath width in bits; must be >= 4 and a power of two
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
start  input  1  launch an operation; sampled only in IDLE
opcode  input  4  operation select; captured with start
ar_flag  input  1  SHL/SHR: 0 = logical shift, 1 = rotate; captured with start
src1  input  WIDTH  operand A; captured with start
src2  input  WIDTH  operand B or shift amount; captured with start
out_en  input  1  result bus drive enable
out  output  WIDTH  result register when out_en=1, else all-Z
flags  output  4  {Z,N,C,V} registered with the result
busy  output  1  high while a multi-cycle op iterates
done  output  1  one-cycle pulse when out/flags update

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - result=0, flags=0000, busy=0, done=0, state=IDLE.
  - Reset mid-MUL/DIV aborts the operation; no done pulse follows.
- States:
  - IDLE: start=1 with a single-cycle opcode registers the result at that edge; done=1 next cycle; stays in IDLE.
  - IDLE -> MUL (opcode 0101) or DIV (0110) on start. Operands and ar_flag are latched.
  - MUL/DIV: one iteration per cycle, WIDTH cycles, busy=1. After the last iteration: result/flags written, done=1, return to IDLE.
  - MUL/DIV latency: done is high exactly WIDTH+1 cycles after the start edge.
- start while busy=1 is ignored; input changes while busy have no effect.
- Back-to-back single-cycle starts are legal every cycle: one done per start.
- Result and flags hold their values until the next completion.
- out_en only gates the bus. It never affects state.
- Opcodes:
  - 0011 ADD: WIDTH-bit sum. C = carry out. V = signed overflow.
  - 0100 SUB: src1-src2. C = borrow (src1<src2 unsigned). V = signed overflow.
  - 0101 MUL: unsigned, low WIDTH bits. C = V = 1 iff high half nonzero.
  - 0110 DIV: unsigned quotient, remainder discarded.
    - src2=0: completes as a single-cycle op (no busy), result = all ones, C=0, V=1.
  - 0111 AND, 1000 OR, 1001 XOR: C = V = 0.
  - 1010 SHL/ROL, 1011 SHR/ROR, common rules:
    - Amount = src2[SHW-1:0] (mod WIDTH).
    - Logical: C = last bit shifted out; amount 0 -> C=0.
    - Rotate: C = bit moved across the end; amount 0 -> C=0.
    - V=0.
  - Any other opcode: NOP. done pulses; result and flags unchanged.
- Flags on every non-NOP completion: Z = (result==0), N = result[WIDTH-1].

Optional Feature:
ALU_DIV_EN
- Defined: iterative DIV as above (WIDTH cycles, divide-by-zero shortcut).
- Undefined: no divider logic is built. Opcode 0110 completes single-cycle with result=0, flags Z=1, N=0, C=0, V=1, and busy never rises.

Test Plan:
- WIDTH=16. rst for 2 cycles, then start ADD src1=10 src2=5 -> next cycle done=1, out=15, flags=0000; out_en=0 -> out=Z.
- SUB 5-10 -> out=65531, flags=0110 (N=1, C=1); SUB 10-10 -> out=0, flags=1000.
- MUL 300*300 -> busy high 16 cycles, done exactly 17 cycles after start, out=24464, flags=0011. A start pulse mid-MUL is ignored (one done only).
- DIV 10/5 -> out=2 after 17 cycles. DIV 7/0 -> next cycle out=65535, flags=0101, busy stays 0. Without ALU_DIV_EN, 10/5 -> out=0, flags=1001.
- ROL 0x8001 by 1 (ar_flag=1) -> 0x0003, C=1. SHL 0x8001 by 1 -> 0x0002, C=1. SHR 10 by 17 -> 5, C=0. ROR 0x0001 by 1 -> 0x8000, N=1, C=1.
- rst asserted 5 cycles into MUL 300*300 -> next cycle busy=0, out=0, flags=0000; no done pulse; a fresh ADD then completes normally.
